// File: rtl/result_checker_pkg.sv
// Shared mode codes, FSM encoding and scan-window lookup for the end-of-run checker.
package result_checker_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SORT   = 2'd1;
    localparam logic [1:0] MODE_FIBO   = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    localparam int unsigned WIN_W = 16;
    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIN_W-1:0] base;
        logic [WIN_W-1:0] len;
    } window_t;

    // Memory window scanned for a given mode; reserved mode yields an empty window.
    function automatic window_t mode_window(input logic [1:0] mode,
                                            input int unsigned sort_base,
                                            input int unsigned sort_len,
                                            input int unsigned fibo_len);
        window_t w;
        w.base = '0;
        w.len  = '0;
        case (mode)
            MODE_SINGLE: begin
                w.base = WIN_W'(0);
                w.len  = WIN_W'(1);
            end
            MODE_SORT: begin
                w.base = WIN_W'(sort_base);
                w.len  = WIN_W'(sort_len);
            end
            MODE_FIBO: begin
                w.base = WIN_W'(1);
                w.len  = WIN_W'(fibo_len);
            end
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// Read port between the checker (master) and data memory (slave); data returns one cycle after rd_en.
interface result_checker_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 10
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/result_checker_expect_gen.sv
// Expected-word sequence: zero, signed ramp, or Fibonacci wrapping at DATA_W bits.
module chk_expect_gen
    import result_checker_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int          SORT_FIRST = -3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic              advance,
    output logic [DATA_W-1:0] expected
);

    logic [1:0]        mode_q;
    logic [DATA_W-1:0] prev2;

    // expected doubles as prev1 of the Fibonacci pair
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_SINGLE;
            expected <= '0;
            prev2    <= '0;
        end else if (load) begin
            mode_q <= mode;
            prev2  <= '0;
            case (mode)
                MODE_SORT: expected <= DATA_W'(SORT_FIRST);
                MODE_FIBO: expected <= DATA_W'(1);
                default:   expected <= '0;
            endcase
        end else if (advance) begin
            case (mode_q)
                MODE_SORT: expected <= expected + DATA_W'(1);
                MODE_FIBO: begin
                    expected <= expected + prev2;
                    prev2    <= expected;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/result_checker.sv
// End-of-run checker: waits for halt, scans a memory window against an expected sequence, reports the result.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned SORT_BASE  = 11,
    parameter int unsigned SORT_LEN   = 10,
    parameter int          SORT_FIRST = -3,
    parameter int unsigned FIBO_LEN   = 20,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic [1:0]        mode,
    result_checker_if.master  mem,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  err_index,
    output logic [DATA_W-1:0] err_data,
    output logic [CNT_W-1:0]  run_cycles
);

    state_e            state, state_nxt;
    logic              rd_en_q, rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_nxt;
    logic [WIN_W-1:0]  issue_left, issue_left_nxt;
    logic [WIN_W-1:0]  win_len, win_len_nxt;
    logic [IDX_W-1:0]  cmp_idx, cmp_idx_nxt, cmp_k;
    logic              cmp_valid, cmp_valid_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic              done_nxt, pass_nxt, timeout_nxt;
    logic [IDX_W-1:0]  err_index_nxt;
    logic [DATA_W-1:0] err_data_nxt;
    logic [CNT_W-1:0]  run_cycles_nxt;
    logic [DATA_W-1:0] expected;
    window_t           win;
    logic              mismatch_c, load_c, advance_c;

    assign mem.rd_en   = rd_en_q;
    assign mem.rd_addr = rd_addr_q;

    assign win        = mode_window(mode, SORT_BASE, SORT_LEN, FIBO_LEN);
    assign cmp_k      = cmp_idx + IDX_W'(1);
    assign mismatch_c = cmp_valid && (mem.rd_data != expected);
    assign load_c     = (state == ST_IDLE) && halt;
    assign advance_c  = (state == ST_SCAN) && cmp_valid;

    chk_expect_gen #(
        .DATA_W     (DATA_W),
        .SORT_FIRST (SORT_FIRST)
    ) u_expect (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .mode     (mode),
        .advance  (advance_c),
        .expected (expected)
    );

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            issue_left <= '0;
            win_len    <= '0;
            cmp_idx    <= '0;
            cmp_valid  <= 1'b0;
            mode_q     <= MODE_SINGLE;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_index  <= '0;
            err_data   <= '0;
            run_cycles <= '0;
        end else begin
            state      <= state_nxt;
            rd_en_q    <= rd_en_nxt;
            rd_addr_q  <= rd_addr_nxt;
            issue_left <= issue_left_nxt;
            win_len    <= win_len_nxt;
            cmp_idx    <= cmp_idx_nxt;
            cmp_valid  <= cmp_valid_nxt;
            mode_q     <= mode_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            timeout    <= timeout_nxt;
            err_index  <= err_index_nxt;
            err_data   <= err_data_nxt;
            run_cycles <= run_cycles_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        rd_en_nxt      = rd_en_q;
        rd_addr_nxt    = rd_addr_q;
        issue_left_nxt = issue_left;
        win_len_nxt    = win_len;
        cmp_idx_nxt    = cmp_idx;
        cmp_valid_nxt  = cmp_valid;
        mode_nxt       = mode_q;
        done_nxt       = done;
        pass_nxt       = pass;
        timeout_nxt    = timeout;
        err_index_nxt  = err_index;
        err_data_nxt   = err_data;
        run_cycles_nxt = run_cycles;

        case (state)
            ST_IDLE: begin
                if (halt) begin
                    mode_nxt = mode;
                    if (mode == MODE_RSVD) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b0;
                    end else begin
                        state_nxt      = ST_SCAN;
                        rd_en_nxt      = 1'b1;
                        rd_addr_nxt    = ADDR_W'(win.base);
                        issue_left_nxt = win.len - WIN_W'(1);
                        win_len_nxt    = win.len;
                        cmp_idx_nxt    = '0;
                        cmp_valid_nxt  = 1'b0;
                    end
                end else if (run_cycles == CNT_W'(TIMEOUT)) begin
                    state_nxt   = ST_DONE;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    pass_nxt    = 1'b0;
                end else if (run_cycles != '1) begin
                    run_cycles_nxt = run_cycles + CNT_W'(1);
                end
            end

            ST_SCAN: begin
                cmp_valid_nxt = rd_en_q;
                if (rd_en_q && (issue_left != '0)) begin
                    rd_en_nxt      = 1'b1;
                    rd_addr_nxt    = rd_addr_q + ADDR_W'(1);
                    issue_left_nxt = issue_left - WIN_W'(1);
                end else begin
                    rd_en_nxt = 1'b0;
                end
                if (cmp_valid) begin
                    cmp_idx_nxt = cmp_k;
                    if (mismatch_c) begin
                        state_nxt     = ST_DONE;
                        done_nxt      = 1'b1;
                        pass_nxt      = 1'b0;
                        err_index_nxt = (mode_q == MODE_SINGLE) ? '0 : cmp_k;
                        err_data_nxt  = mem.rd_data;
                        rd_en_nxt     = 1'b0;
                        cmp_valid_nxt = 1'b0;
                    end else if (WIN_W'(cmp_k) == win_len) begin
                        state_nxt     = ST_DONE;
                        done_nxt      = 1'b1;
                        pass_nxt      = 1'b1;
                        rd_en_nxt     = 1'b0;
                        cmp_valid_nxt = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                rd_en_nxt     = 1'b0;
                cmp_valid_nxt = 1'b0;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
